// File: rtl/stage_ex.sv
// Execute stage: operand forwarding, ALU, memory address generation and an iterative restoring divider.
// Latency: single-cycle ops are registered at the next edge; divides appear DATA_W+1 edges after issue.
// Backpressure: stall/!en hold the output registers; busy (combinational) asks upstream to hold its inputs.
module stage_ex #(
    parameter int DATA_W      = 32,
    parameter int REG_ADDR_W  = 5,
    parameter int DATA_ADDR_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   stall,
    input  logic                   flush,
    input  logic [3:0]             alu_op,
    input  logic                   use_imm,
    input  logic [DATA_W-1:0]      reg_data_rs1,
    input  logic [DATA_W-1:0]      reg_data_rs2,
    input  logic [DATA_W-1:0]      imm,
    input  logic [1:0]             fwd_a_sel,
    input  logic [1:0]             fwd_b_sel,
    input  logic [DATA_W-1:0]      ffw_MM_data_wr,
    input  logic [DATA_W-1:0]      ffw_WB_data,
    input  logic                   is_load,
    input  logic                   is_store,
    input  logic                   is_atomic,
    input  logic                   reg_wr,
    input  logic [REG_ADDR_W-1:0]  reg_addr_rd,
    output logic                   busy,
    output logic                   out_is_load,
    output logic                   out_is_store,
    output logic                   out_is_atomic,
    output logic                   out_reg_wr,
    output logic [REG_ADDR_W-1:0]  out_reg_addr_rd,
    output logic [DATA_W-1:0]      out_reg_data_rd,
    output logic [DATA_ADDR_W-1:0] out_alu_mem_addr,
    output logic                   out_flush
);

    localparam int SH_W  = $clog2(DATA_W);
    localparam int CNT_W = SH_W + 1;
    localparam logic [DATA_W-1:0] MIN_VAL = {1'b1, {(DATA_W-1){1'b0}}};

    localparam logic [3:0] OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_AND  = 4'd2,  OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4,  OP_SLL  = 4'd5,  OP_SRL  = 4'd6,  OP_SRA  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8,  OP_SLTU = 4'd9,  OP_MUL  = 4'd10, OP_DIV  = 4'd11;
    localparam logic [3:0] OP_DIVU = 4'd12, OP_REM  = 4'd13, OP_REMU = 4'd14;

    typedef enum logic [1:0] {S_IDLE, S_DIV_RUN, S_DIV_DONE} state_t;

    state_t             state_q;
    logic [DATA_W-1:0]  quo_q, rem_q, dvsr_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               neg_q_q, neg_r_q, div_is_quo_q;

    logic [DATA_W-1:0]  fwd_a, fwd_b_raw, op_b, alu_res, abs_a, abs_b, div_res, slot_data, mem_sum;
    logic [SH_W-1:0]    shamt;
    logic               is_div_op, is_signed_div, div_zero, div_ovf, div_start, adv;
    logic [DATA_W:0]    rem_shift, rem_diff;
    logic               step_ok;
    logic [DATA_W-1:0]  rem_next, quo_next;

    // Forwarding muxes; select code 3 falls back to the register file.
    always_comb begin
        fwd_a = reg_data_rs1;
        case (fwd_a_sel)
            2'd1:    fwd_a = ffw_MM_data_wr;
            2'd2:    fwd_a = ffw_WB_data;
            default: fwd_a = reg_data_rs1;
        endcase
        fwd_b_raw = reg_data_rs2;
        case (fwd_b_sel)
            2'd1:    fwd_b_raw = ffw_MM_data_wr;
            2'd2:    fwd_b_raw = ffw_WB_data;
            default: fwd_b_raw = reg_data_rs2;
        endcase
    end

    assign op_b          = use_imm ? imm : fwd_b_raw;
    assign shamt         = op_b[SH_W-1:0];
    assign mem_sum       = fwd_a + imm;
    assign is_div_op     = (alu_op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU});
    assign is_signed_div = (alu_op == OP_DIV) || (alu_op == OP_REM);
    assign div_zero      = (op_b == '0);
    assign div_ovf       = is_signed_div && (fwd_a == MIN_VAL) && (op_b == '1);
    // Zero divisor and MIN/-1 are resolved in one cycle, so they never start the FSM.
    assign div_start     = en && !flush && is_div_op && !div_zero && !div_ovf;
    assign busy          = !rst && (((state_q == S_IDLE) && div_start) || (state_q == S_DIV_RUN));
    assign adv           = en && !stall && !busy;
    assign abs_a         = (is_signed_div && fwd_a[DATA_W-1]) ? -fwd_a : fwd_a;
    assign abs_b         = (is_signed_div && op_b[DATA_W-1])  ? -op_b  : op_b;

    // Single-cycle ALU, including the divide corner cases that bypass the iterative divider.
    always_comb begin
        alu_res = fwd_a + op_b;
        case (alu_op)
            OP_SUB:  alu_res = fwd_a - op_b;
            OP_AND:  alu_res = fwd_a & op_b;
            OP_OR:   alu_res = fwd_a | op_b;
            OP_XOR:  alu_res = fwd_a ^ op_b;
            OP_SLL:  alu_res = fwd_a << shamt;
            OP_SRL:  alu_res = fwd_a >> shamt;
            OP_SRA:  alu_res = $signed(fwd_a) >>> shamt;
            OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(fwd_a) < $signed(op_b))};
            OP_SLTU: alu_res = {{(DATA_W-1){1'b0}}, (fwd_a < op_b)};
            OP_MUL:  alu_res = fwd_a * op_b;
            OP_DIV:  alu_res = div_zero ? '1 : (div_ovf ? MIN_VAL : '0);
            OP_DIVU: alu_res = div_zero ? '1 : '0;
            OP_REM:  alu_res = div_zero ? fwd_a : '0;
            OP_REMU: alu_res = div_zero ? fwd_a : '0;
            default: alu_res = fwd_a + op_b;
        endcase
    end

    // One restoring step: shift the next dividend bit in, subtract if it fits.
    assign rem_shift = {rem_q, quo_q[DATA_W-1]};
    assign rem_diff  = rem_shift - {1'b0, dvsr_q};
    assign step_ok   = !rem_diff[DATA_W];
    assign rem_next  = step_ok ? rem_diff[DATA_W-1:0] : rem_shift[DATA_W-1:0];
    assign quo_next  = {quo_q[DATA_W-2:0], step_ok};
    assign div_res   = div_is_quo_q ? (neg_q_q ? -quo_q : quo_q) : (neg_r_q ? -rem_q : rem_q);
    assign slot_data = (is_store || is_atomic) ? fwd_b_raw
                     : ((state_q == S_DIV_DONE) ? div_res : alu_res);

    // Divider FSM: latch magnitudes on start, iterate while enabled, hold the result until it advances.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            quo_q        <= '0;
            rem_q        <= '0;
            dvsr_q       <= '0;
            cnt_q        <= '0;
            neg_q_q      <= 1'b0;
            neg_r_q      <= 1'b0;
            div_is_quo_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (div_start) begin
                        quo_q        <= abs_a;
                        rem_q        <= '0;
                        dvsr_q       <= abs_b;
                        cnt_q        <= '0;
                        neg_q_q      <= is_signed_div && (fwd_a[DATA_W-1] ^ op_b[DATA_W-1]);
                        neg_r_q      <= is_signed_div && fwd_a[DATA_W-1];
                        div_is_quo_q <= (alu_op == OP_DIV) || (alu_op == OP_DIVU);
                        state_q      <= S_DIV_RUN;
                    end
                end
                S_DIV_RUN: begin
                    if (en) begin
                        quo_q <= quo_next;
                        rem_q <= rem_next;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(DATA_W-1)) begin
                            state_q <= S_DIV_DONE;
                        end
                    end
                end
                S_DIV_DONE: begin
                    if (adv) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Output slot to MM: bubbles while the divider is busy, new slot on advance, hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_is_load      <= 1'b0;
            out_is_store     <= 1'b0;
            out_is_atomic    <= 1'b0;
            out_reg_wr       <= 1'b0;
            out_reg_addr_rd  <= '0;
            out_reg_data_rd  <= '0;
            out_alu_mem_addr <= '0;
            out_flush        <= 1'b1;
        end else if (en && !stall) begin
            if (busy) begin
                out_is_load   <= 1'b0;
                out_is_store  <= 1'b0;
                out_is_atomic <= 1'b0;
                out_reg_wr    <= 1'b0;
                out_flush     <= 1'b1;
            end else begin
                out_is_load      <= is_load;
                out_is_store     <= is_store;
                out_is_atomic    <= is_atomic;
                out_reg_wr       <= reg_wr;
                out_reg_addr_rd  <= reg_addr_rd;
                out_reg_data_rd  <= slot_data;
                out_alu_mem_addr <= mem_sum[DATA_ADDR_W-1:0];
                out_flush        <= flush;
            end
        end
    end

endmodule

// File: doc/stage_ex.md
Name: stage_ex

Overview:
- Execute stage of the core pipeline. It sits between instruction decode and STAGE_MM.
- Resolves operand forwarding from MM and WB, computes ALU results and memory addresses, and runs an iterative divider that stalls upstream stages.
- Registers everything STAGE_MM consumes: load/store/atomic flags, reg write, rd address, data (ALU result or store data), memory address and a flush/bubble bit.

Parameters:
- DATA_W, 32, datapath width. Must be a power of two ≥ 8.
- REG_ADDR_W, 5, register index width.
- DATA_ADDR_W, 32, memory address width. The address is the low DATA_ADDR_W bits of the sum.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- en  in  1  global pipeline enable.
- stall  in  1  downstream hold (memory wait). Holds the output registers.
- flush  in  1  incoming slot is a bubble.
- alu_op  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 MUL, 11 DIV, 12 DIVU, 13 REM, 14 REMU. Code 15 behaves as ADD.
- use_imm  in  1  operand B = imm instead of rs2.
- reg_data_rs1, reg_data_rs2  in  DATA_W  register file reads.
- imm  in  DATA_W  sign-extended immediate.
- fwd_a_sel, fwd_b_sel  in  2  0 register file, 1 ffw_MM_data_wr, 2 ffw_WB_data, 3 treated as 0.
- ffw_MM_data_wr  in  DATA_W  forward value from MM.
- ffw_WB_data  in  DATA_W  forward value from WB.
- is_load, is_store, is_atomic, reg_wr  in  1  decoded control.
- reg_addr_rd  in  REG_ADDR_W  destination register.
- busy  out  1  combinational. Upstream must hold all inputs stable while high.
- out_is_load, out_is_store, out_is_atomic, out_reg_wr  out  1  to MM.
- out_reg_addr_rd  out  REG_ADDR_W  to MM.
- out_reg_data_rd  out  DATA_W  ALU result. For store/atomic it carries the forwarded rs2 value.
- out_alu_mem_addr  out  DATA_ADDR_W  fwdA + imm.
- out_flush  out  1  bubble marker to MM.

Behaviour:
- Reset (async) values:
  - out_flush = 1.
  - All other outputs = 0; busy = 0.
  - FSM = IDLE; divider registers cleared.
  - Reset mid-division abandons the operation; no result is produced.
- Operand selection:
  - fwdA is chosen by fwd_a_sel.
  - fwdB_raw is chosen by fwd_b_sel.
  - Operand B = use_imm ? imm : fwdB_raw.
- Advance condition: adv = en && !stall && !busy. On adv:
  - Output registers load the slot.
  - out_reg_data_rd = (is_store||is_atomic) ? fwdB_raw : result.
  - out_flush = flush.
- Outputs hold when en=0 or stall=1.
- Single-cycle ops (0–10):
  - Result is registered at the next edge.
  - Shifts use B[log2(DATA_W)-1:0].
  - SLT/SLTU return 1 or 0, zero-extended.
  - MUL returns the low DATA_W bits of the product.
- Division FSM: IDLE → DIV_RUN → DIV_DONE → IDLE.
  - IDLE:
    - If en && !flush && alu_op in 11–14 and the divisor is non-zero and the case is not signed overflow, then busy=1 combinationally in this cycle T.
    - At the edge, latch |dividend|, |divisor|, sign info and op; counter=0; go to DIV_RUN.
  - DIV_RUN:
    - One restoring-division step per cycle; busy=1.
    - After DATA_W steps (edge ending cycle T+DATA_W) go to DIV_DONE.
  - DIV_DONE:
    - busy=0. Apply signs: quotient negated if signs differ; remainder takes the dividend sign.
    - If adv, registers load the divider result and the FSM returns to IDLE.
    - If stall, remain in DIV_DONE holding the result.
  - While busy, out_* registers take bubbles on each edge where en && !stall: out_flush=1, out_reg_wr=0, load/store/atomic=0.
  - Latency: a divide issued in cycle T appears on the outputs after the edge ending cycle T+DATA_W+1.
  - Divide by zero (single cycle, no FSM): DIV/DIVU quotient = all ones; REM/REMU = dividend.
  - Signed overflow (MIN / -1, single cycle): DIV = MIN; REM = 0.
  - flush=1 with a divide op: treated as a bubble and never starts the FSM.
  - en=0 during DIV_RUN: iteration pauses (counter holds).

Test Plan:
- ADD with fwd_a_sel=1 (MM value 0x10) and imm 0x4, use_imm=1 → next cycle out_reg_data_rd = 0x14, out_flush = 0.
- Store, rs1 = 0x100, imm = 0x8, fwd_b_sel = 2 (WB = 0xDEADBEEF) → out_alu_mem_addr = 0x108, out_reg_data_rd = 0xDEADBEEF, out_is_store = 1.
- DIV −7/2 → busy for 33 cycles; result quotient 0xFFFFFFFD. REM −7/2 → 0xFFFFFFFF. out_flush = 1 on every intermediate output cycle.
- DIVU 5/0 → 0xFFFFFFFF in one cycle with busy never high. DIV 0x80000000/−1 → 0x80000000. REM of the same → 0.
- stall held for 3 cycles in DIV_DONE → outputs and busy unchanged; the result appears on the first non-stalled edge.
- rst asserted mid-DIV_RUN → out_flush = 1 and busy = 0 immediately; after release the next ADD completes normally.
